// File: rtl/store_buffer.sv
// Posted-write store buffer between the core load/store path and data_memory.
// Define SB_COALESCE_EN to merge stores to an already-buffered address.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_fwd,
    output logic [AW-1:0]            mem_address,
    output logic [DW-1:0]            mem_write_data,
    output logic                     mem_write,
    output logic                     mem_read,
    input  logic [DW-1:0]            mem_read_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt_q;

    logic drain;
    logic alloc;
    logic coalesce;
    logic fwd_hit;
    logic [DW-1:0] fwd_data;

    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign st_ready = (cnt_q != CW'(DEPTH));

    // Reset wins over drain so pending stores are discarded, not written.
    assign drain = !empty && !ld_req && !rst;
    assign alloc = st_valid && st_ready && !coalesce;

    assign mem_read       = ld_req;
    assign mem_write      = drain;
    assign mem_address    = ld_req ? ld_addr : addr_q[head];
    assign mem_write_data = data_q[head];

    // Scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (vld_q[idx] && addr_q[idx] == ld_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_fwd  = ld_req && fwd_hit;
    assign ld_data = ld_fwd ? fwd_data : mem_read_data;

`ifdef SB_COALESCE_EN
    logic st_hit;
    logic [PW-1:0] st_idx;

    always_comb begin
        logic [PW-1:0] sidx;
        sidx   = '0;
        st_hit = 1'b0;
        st_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sidx = head + PW'(k);
            if (vld_q[sidx] && addr_q[sidx] == st_addr) begin
                st_hit = 1'b1;
                st_idx = sidx;
            end
        end
    end

    // A head entry leaving this cycle cannot absorb the store.
    assign coalesce = st_valid && st_hit
                      && !(drain && st_idx == head);
`else
    assign coalesce = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            if (drain) begin
                vld_q[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (alloc) begin
                addr_q[tail] <= st_addr;
                data_q[tail] <= st_data;
                vld_q[tail]  <= 1'b1;
                tail         <= tail + 1'b1;
            end
`ifdef SB_COALESCE_EN
            if (coalesce) begin
                data_q[st_idx] <= st_data;
            end
`endif
            cnt_q <= cnt_q + CW'(alloc) - CW'(drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a monitor checks every memory write
// and every load response against queues filled by the stimulus.
module tb_store_buffer;
    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_fwd;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic [2:0]  count;
    logic        empty;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk(clk),
        .rst(rst),
        .st_valid(st_valid),
        .st_addr(st_addr),
        .st_data(st_data),
        .st_ready(st_ready),
        .ld_req(ld_req),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_fwd(ld_fwd),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .mem_read_data(mem_read_data),
        .count(count),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory: combinational read, write at the edge
    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    typedef struct packed {
        logic        f;
        logic [15:0] d;
    } ld_t;

    wr_t wr_q[$];
    ld_t ld_q[$];
    wr_t we;
    ld_t le;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops an expectation whenever the DUT writes or loads.
    always @(negedge clk) begin
        if (mem_write) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(mem_write), 32'd0);
            end else begin
                we = wr_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(we.a));
                check("wr_data", 32'(mem_write_data), 32'(we.d));
            end
        end
        if (ld_req) begin
            check("ld_mem_read", 32'(mem_read), 32'd1);
            if (ld_q.size() == 0) begin
                check("ld_unexpected", 32'(ld_req), 32'd0);
            end else begin
                le = ld_q.pop_front();
                check("ld_fwd", 32'(ld_fwd), 32'(le.f));
                check("ld_data", 32'(ld_data), 32'(le.d));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [15:0] sa,
                         input logic [15:0] sd, input logic lr,
                         input logic [15:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_req   = lr;
        ld_addr  = la;
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic exp_ld(input logic f, input logic [15:0] d);
        ld_q.push_back({f, d});
    endtask

    task automatic wait_empty(input string name, input int max);
        for (int c = 0; c < max; c++) begin
            if (empty) break;
            tick();
        end
        check(name, 32'(empty), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // reset state
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_ld_fwd", 32'(ld_fwd), 32'd0);
        rst = 1'b0;
        tick();

        // single store drains next cycle, then reads back from memory
        drive(1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0);
        exp_wr(16'h0010, 16'h1234);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        check("t2_mem_write", 32'(mem_write), 32'd1);
        tick();
        check("t2_empty", 32'(empty), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
        exp_ld(1'b0, 16'h1234);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();

        // loads block drain; fill to full, 5th store dropped
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i),
                  1'b1, 16'(16'h0001 + i));
            exp_ld(1'b0, 16'h0000);
            if (i < 4) exp_wr(16'(16'h0100 + i), 16'(16'hA000 + i));
            #1;
            check("t3_mem_write", 32'(mem_write), 32'd0);
            check("t3_count", 32'(count), 32'(i));
            check("t3_st_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        check("t3_full_count", 32'(count), 32'd4);
        for (int j = 0; j < 4; j++) begin
            check("t3_drain_wr", 32'(mem_write), 32'd1);
            tick();
        end
        check("t3_empty", 32'(empty), 32'd1);

        // same address twice: youngest forwarded
        drive(1'b1, 16'h0020, 16'h0001, 1'b1, 16'h0030);
        exp_ld(1'b0, 16'h0000);
`ifndef SB_COALESCE_EN
        exp_wr(16'h0020, 16'h0001);
`endif
        tick();
        drive(1'b1, 16'h0020, 16'h0002, 1'b1, 16'h0020);
        exp_ld(1'b1, 16'h0001);
        exp_wr(16'h0020, 16'h0002);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        exp_ld(1'b1, 16'h0002);
        #1;
`ifdef SB_COALESCE_EN
        check("t4_count", 32'(count), 32'd1);
`else
        check("t4_count", 32'(count), 32'd2);
`endif
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        wait_empty("t4_drained", 8);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        exp_ld(1'b0, 16'h0002);
        tick();

        // steady push+drain at count=2, wrapping pointers
        drive(1'b1, 16'h0200, 16'hB000, 1'b1, 16'h0040);
        exp_ld(1'b0, 16'h0000);
        exp_wr(16'h0200, 16'hB000);
        tick();
        drive(1'b1, 16'h0201, 16'hB001, 1'b1, 16'h0040);
        exp_ld(1'b0, 16'h0000);
        exp_wr(16'h0201, 16'hB001);
        tick();
        for (int i = 2; i < 8; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 16'(16'hB000 + i),
                  1'b0, 16'h0);
            exp_wr(16'(16'h0200 + i), 16'(16'hB000 + i));
            #1;
            check("t5_count", 32'(count), 32'd2);
            check("t5_mem_write", 32'(mem_write), 32'd1);
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        wait_empty("t5_drained", 8);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0200);
        exp_ld(1'b0, 16'hB000);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0204);
        exp_ld(1'b0, 16'hB004);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0207);
        exp_ld(1'b0, 16'hB007);
        tick();

        // reset with pending stores discards them
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0300 + i), 16'(16'hC000 + i),
                  1'b1, 16'h0050);
            exp_ld(1'b0, 16'h0000);
            tick();
        end
        check("t6_pending", 32'(count), 32'd3);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        rst = 1'b1;
        #1;
        check("t6_rst_no_write", 32'(mem_write), 32'd0);
        tick();
        rst = 1'b0;
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_st_ready", 32'(st_ready), 32'd1);
        repeat (3) tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0300);
        exp_ld(1'b0, 16'h0000);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
        exp_ld(1'b0, 16'h1234);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        repeat (2) tick();

        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("ld_q_drained", 32'(ld_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
